ppi_bus_master: RTL and testbench

Host-side bus initiator for the 8255-style PPI. Converts single-beat read/write commands on a valid/ready interface into correctly sequenced chip-bus cycles: CSbar, RDbar, WRbar, Addresslines and the bidirectional PortD data bus. It sits between the control logic and the PPI chip, driving the chip bus the PPI responds on, with programmable setup, strobe and hold widths.

---
 rtl/ppi_bus_master_pkg.sv | 41 ++++
 rtl/ppi_bus_master_if.sv | 28 ++
 rtl/ppi_bus_master_phase_timer.sv | 37 +++
 rtl/ppi_bus_master.sv | 185 ++++++++++++++++++
 tb/tb_ppi_bus_master.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/ppi_bus_master_pkg.sv
// Shared definitions for the PPI bus master: register addresses, FSM
// encoding, the PPI control-register reset value and phase-length helpers.
package ppi_pkg;

  localparam logic [1:0] PPI_ADDR_PA   = 2'b00;
  localparam logic [1:0] PPI_ADDR_PB   = 2'b01;
  localparam logic [1:0] PPI_ADDR_PC   = 2'b10;
  localparam logic [1:0] PPI_ADDR_CTRL = 2'b11;

  // Mode word the PPI itself comes out of reset with (all ports input).
  localparam logic [7:0] PPI_CTRL_RESET = 8'h9B;

  // Largest legal setup/strobe/hold length; the phase counter is 4 bits.
  localparam int PPI_PARAM_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } ppi_state_e;

  // Counter preload for a phase of 'cyc' cycles, clamped to the legal range.
  function automatic logic [3:0] phase_load(input int cyc);
    int c;
    if (cyc < 1) begin
      c = 1;
    end else if (cyc > PPI_PARAM_MAX) begin
      c = PPI_PARAM_MAX;
    end else begin
      c = cyc;
    end
    return 4'(c - 1);
  endfunction

  // A control-register write with bit 7 set is a mode word; bit 7 clear is BSR.
  function automatic logic is_mode_word(input logic [1:0] addr, input logic [7:0] wdata);
    return (addr == PPI_ADDR_CTRL) && wdata[7];
  endfunction

endpackage

// File: rtl/ppi_bus_master_if.sv
// Command/response handshake and PPI chip-bus control lines of the bus
// master. The bidirectional data bus stays a plain inout on the top module.
interface ppi_bus_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       busy;
  logic       CSbar;
  logic       RDbar;
  logic       WRbar;
  logic [1:0] Addresslines;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, busy,
    output CSbar, RDbar, WRbar, Addresslines
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, busy,
    input  CSbar, RDbar, WRbar, Addresslines
  );
endinterface

// File: rtl/ppi_bus_master_phase_timer.sv
// Loadable 4-bit down-counter shared by the SETUP, STROBE and HOLD phases.
// 'done' is high while the count is zero: the current phase ends next edge.
module ppi_phase_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic       done
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count: preload on phase entry, otherwise count down and stop at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == 4'd0);

endmodule

// File: rtl/ppi_bus_master.sv
// Host-side bus initiator for an 8255-style PPI. Turns single-beat
// valid/ready commands into SETUP/STROBE/HOLD chip-bus cycles. Every output
// is a flop decoded from the next state, so cmd_* never reach the pins
// combinationally. Optional macro PPI_MASTER_SHADOW_EN adds cfg_shadow, a
// copy of the last mode word written to the control register.
module ppi_bus_master
  import ppi_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                    CLK,
  input  logic                    RESET,
  ppi_bus_master_if.master        bus,
  inout  wire  [7:0]              PortD
`ifdef PPI_MASTER_SHADOW_EN
  ,
  output logic [7:0]              cfg_shadow
`endif
);

  ppi_state_e state_q, state_d;
  logic       write_q, write_d;
  logic [1:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       cs_q, cs_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic       oe_q, oe_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       accept;
  logic       timer_load;
  logic [3:0] timer_val;
  logic       timer_done;
`ifdef PPI_MASTER_SHADOW_EN
  logic [7:0] shadow_q, shadow_d;
`endif

  ppi_phase_timer u_timer (
    .clk      (CLK),
    .rst      (RESET),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  assign accept = (state_q == ST_IDLE) && ready_q && bus.cmd_valid;

  // Next-state, command latching, read capture and registered-output decode.
  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    timer_load  = 1'b0;
    timer_val   = 4'd0;
`ifdef PPI_MASTER_SHADOW_EN
    shadow_d    = shadow_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          write_d    = bus.cmd_write;
          addr_d     = bus.cmd_addr;
          wdata_d    = bus.cmd_wdata;
          state_d    = ST_SETUP;
          timer_load = 1'b1;
          timer_val  = phase_load(SETUP_CYC);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (timer_done) begin
          state_d    = ST_STROBE;
          timer_load = 1'b1;
          timer_val  = phase_load(STROBE_CYC);
        end else begin
          state_d = ST_SETUP;
        end
      end
      ST_STROBE: begin
        if (timer_done) begin
          // Sample the PPI while RDbar is still low, on the edge that ends it.
          if (!write_q) begin
            rdata_d = PortD;
          end else begin
            rdata_d = rdata_q;
          end
          state_d    = ST_HOLD;
          timer_load = 1'b1;
          timer_val  = phase_load(HOLD_CYC);
        end else begin
          state_d = ST_STROBE;
        end
      end
      ST_HOLD: begin
        if (timer_done) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
`ifdef PPI_MASTER_SHADOW_EN
          if (write_q && is_mode_word(addr_q, wdata_q)) begin
            shadow_d = wdata_q;
          end else begin
            shadow_d = shadow_q;
          end
`endif
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cs_d    = (state_d == ST_IDLE);
    rd_d    = !((state_d == ST_STROBE) && !write_d);
    wr_d    = !((state_d == ST_STROBE) && write_d);
    oe_d    = (state_d != ST_IDLE) && write_d;
    busy_d  = (state_d != ST_IDLE);
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers; reset aborts any cycle and releases PortD.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= ST_IDLE;
      write_q     <= 1'b0;
      addr_q      <= 2'b00;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      rsp_valid_q <= 1'b0;
      cs_q        <= 1'b1;
      rd_q        <= 1'b1;
      wr_q        <= 1'b1;
      oe_q        <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      cs_q        <= cs_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      oe_q        <= oe_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

`ifdef PPI_MASTER_SHADOW_EN
  // Mode-word shadow, reset to the PPI's own power-up mode.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      shadow_q <= PPI_CTRL_RESET;
    end else begin
      shadow_q <= shadow_d;
    end
  end

  assign cfg_shadow = shadow_q;
`endif

  assign bus.cmd_ready    = ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = rdata_q;
  assign bus.busy         = busy_q;
  assign bus.CSbar        = cs_q;
  assign bus.RDbar        = rd_q;
  assign bus.WRbar        = wr_q;
  assign bus.Addresslines = addr_q;
  assign PortD            = oe_q ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_ppi_bus_master.sv
// Directed bench for ppi_bus_master. Instance 0 uses default timing
// (1/2/1), instance 1 uses 3/5/2. The bench plays the PPI: it drives PortD
// with 8'h3C when idle and with the read value during reads, and releases it
// during writes, so any unwanted drive by the block corrupts the observed bus.
module tb_ppi_bus_master;
  import ppi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ppi_bus_master_if if0 ();
  ppi_bus_master_if if1 ();

  logic       pd_en0, pd_en1;
  logic [7:0] pd_val0, pd_val1;
  wire  [7:0] pd0, pd1;
  assign pd0 = pd_en0 ? pd_val0 : 8'hzz;
  assign pd1 = pd_en1 ? pd_val1 : 8'hzz;

`ifdef PPI_MASTER_SHADOW_EN
  logic [7:0] shadow0, shadow1;
`endif

  ppi_bus_master #(.SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(1)) u_dut0 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (if0),
    .PortD (pd0)
`ifdef PPI_MASTER_SHADOW_EN
    , .cfg_shadow (shadow0)
`endif
  );

  ppi_bus_master #(.SETUP_CYC(3), .STROBE_CYC(5), .HOLD_CYC(2)) u_dut1 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (if1),
    .PortD (pd1)
`ifdef PPI_MASTER_SHADOW_EN
    , .cfg_shadow (shadow1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {CSbar, RDbar, WRbar, rsp_valid, busy}
  function automatic logic [4:0] ctl(input int sel);
    if (sel == 0) return {if0.CSbar, if0.RDbar, if0.WRbar, if0.rsp_valid, if0.busy};
    else          return {if1.CSbar, if1.RDbar, if1.WRbar, if1.rsp_valid, if1.busy};
  endfunction

  function automatic logic [7:0] pd(input int sel);
    if (sel == 0) return pd0;
    else          return pd1;
  endfunction

  function automatic logic [7:0] rdata(input int sel);
    if (sel == 0) return if0.rsp_rdata;
    else          return if1.rsp_rdata;
  endfunction

  function automatic logic ready(input int sel);
    if (sel == 0) return if0.cmd_ready;
    else          return if1.cmd_ready;
  endfunction

  function automatic logic [1:0] addr(input int sel);
    if (sel == 0) return if0.Addresslines;
    else          return if1.Addresslines;
  endfunction

  task automatic drive_cmd(input int sel, input logic v, input logic w,
                           input logic [1:0] a, input logic [7:0] d);
    if (sel == 0) begin
      if0.cmd_valid = v; if0.cmd_write = w; if0.cmd_addr = a; if0.cmd_wdata = d;
    end else begin
      if1.cmd_valid = v; if1.cmd_write = w; if1.cmd_addr = a; if1.cmd_wdata = d;
    end
  endtask

  task automatic set_pd(input int sel, input logic en, input logic [7:0] v);
    if (sel == 0) begin pd_en0 = en; pd_val0 = v; end
    else          begin pd_en1 = en; pd_val1 = v; end
  endtask

  // One command from a negedge where the block is idle; returns on the negedge
  // of the rsp_valid cycle. Each cycle is checked against the S/T/H schedule.
  task automatic run_cmd(input int sel, input logic wr, input logic [1:0] a,
                         input logic [7:0] d, input int S, input int T, input int H,
                         input bit hold_valid);
    int L;
    logic [4:0] e;
    L = S + T + H;
    chk($sformatf("ready_pre%0d", sel), 32'(ready(sel)), 32'h1);
    set_pd(sel, !wr, d);
    drive_cmd(sel, 1'b1, wr, a, d);
    @(negedge clk);
    if (!hold_valid) drive_cmd(sel, 1'b0, 1'b0, 2'b00, 8'h00);
    for (int i = 1; i <= L + 1; i++) begin
      if (i > 1) @(negedge clk);
      e[4] = (i > L);
      e[3] = !(!wr && i > S && i <= S + T);
      e[2] = !(wr && i > S && i <= S + T);
      e[1] = (i == L + 1);
      e[0] = (i <= L);
      chk($sformatf("ctl%0d_c%0d", sel, i), 32'(ctl(sel)), 32'(e));
      if (i <= L) begin
        chk($sformatf("addr%0d_c%0d", sel, i), 32'(addr(sel)), 32'(a));
        chk($sformatf("rdy%0d_c%0d", sel, i), 32'(ready(sel)), 32'h0);
        chk($sformatf("portd%0d_c%0d", sel, i), 32'(pd(sel)), 32'(d));
      end
    end
    if (!wr) chk($sformatf("rdata%0d", sel), 32'(rdata(sel)), 32'(d));
    set_pd(sel, 1'b1, 8'h3C);
  endtask

  initial begin
    rst = 1'b1;
    set_pd(0, 1'b1, 8'h3C);
    set_pd(1, 1'b1, 8'h3C);
    drive_cmd(0, 1'b0, 1'b0, 2'b00, 8'h00);
    drive_cmd(1, 1'b0, 1'b0, 2'b00, 8'h00);
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_ctl",   32'(ctl(0)),   32'h1C);
    chk("rst_addr",  32'(addr(0)),  32'h0);
    chk("rst_rdata", 32'(rdata(0)), 32'h0);
    chk("rst_ready", 32'(ready(0)), 32'h0);
    chk("rst_portd", 32'(pd(0)),    32'h3C);
`ifdef PPI_MASTER_SHADOW_EN
    chk("rst_shadow", 32'(shadow0), 32'h9B);
`endif
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready0", 32'(ready(0)), 32'h1);
    chk("rel_ready1", 32'(ready(1)), 32'h1);

    // Default-timing write, then read
    run_cmd(0, 1'b1, PPI_ADDR_PA, 8'hAA, 1, 2, 1, 1'b0);
    run_cmd(0, 1'b0, PPI_ADDR_PB, 8'h90, 1, 2, 1, 1'b0);

    // Back-to-back: mode word then data write, second accepted in rsp cycle
    run_cmd(0, 1'b1, PPI_ADDR_CTRL, 8'h80, 1, 2, 1, 1'b0);
    run_cmd(0, 1'b1, PPI_ADDR_PA,   8'h55, 1, 2, 1, 1'b0);
`ifdef PPI_MASTER_SHADOW_EN
    chk("shadow_mode", 32'(shadow0), 32'h80);
`endif
    run_cmd(0, 1'b1, PPI_ADDR_CTRL, 8'h07, 1, 2, 1, 1'b0);
`ifdef PPI_MASTER_SHADOW_EN
    chk("shadow_bsr", 32'(shadow0), 32'h80);
`endif

    // Long timing on the second instance
    run_cmd(1, 1'b0, PPI_ADDR_PC, 8'h5A, 3, 5, 2, 1'b0);

    // cmd_valid held through a transaction: exactly two accepts, then idle
    run_cmd(0, 1'b1, PPI_ADDR_PB, 8'h33, 1, 2, 1, 1'b1);
    run_cmd(0, 1'b1, PPI_ADDR_PB, 8'h33, 1, 2, 1, 1'b0);
    @(negedge clk);
    chk("held_idle_ctl",   32'(ctl(0)),   32'h1C);
    chk("held_idle_ready", 32'(ready(0)), 32'h1);

    // Reset during the strobe of a write
    set_pd(0, 1'b0, 8'h00);
    drive_cmd(0, 1'b1, 1'b1, PPI_ADDR_PC, 8'hC3);
    @(negedge clk);
    drive_cmd(0, 1'b0, 1'b0, 2'b00, 8'h00);
    @(negedge clk);
    chk("abort_strobe", 32'(ctl(0)), 32'h09);
    chk("abort_pd",     32'(pd(0)),  32'hC3);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ctl",   32'(ctl(0)),   32'h1C);
    chk("abort_ready", 32'(ready(0)), 32'h0);
    chk("abort_addr",  32'(addr(0)),  32'h0);
    chk("abort_rdata", 32'(rdata(0)), 32'h0);
`ifdef PPI_MASTER_SHADOW_EN
    chk("abort_shadow", 32'(shadow0), 32'h9B);
`endif
    set_pd(0, 1'b1, 8'h3C);
    #1;
    chk("abort_portd", 32'(pd(0)), 32'h3C);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ctl",   32'(ctl(0)),   32'h1C);
    chk("post_rst_ready", 32'(ready(0)), 32'h1);
    run_cmd(0, 1'b1, PPI_ADDR_PC, 8'h12, 1, 2, 1, 1'b0);
    @(negedge clk);
    chk("final_portd", 32'(pd(0)), 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
